gated_clk_en_ctrl: RTL
======================

// Module: gated_clk_en_ctrl
// PURPOSE
//  Idle-detect enable controller that drives local_en of one gated clock cell.
//  Watches a module's activity (busy, request lines) on the free-running clock.
//  Drops local_en after IDLE_THRESH consecutive idle cycles.
//  On new activity it re-enables the clock and holds requesters off (clk_rdy=0)
//  for WAKE_DLY cycles before acknowledging.
// PARAMETERS
//  NUM_REQ      4   number of activity request lines
//  IDLE_THRESH  8   consecutive idle cycles before gating (legal 1..2^CNT_W-1)
//  WAKE_DLY     2   cycles from local_en rise to clk_rdy rise (legal >=1)
//  CNT_W        4   width of idle and wake counters
// PORTS
//  forever_cpuclk  in   1        free-running clock, never gated
//  cpurst          in   1        synchronous reset, active-high
//  ctrl_gate_en    in   1        1 = gating allowed, 0 = clock forced on
//  busy            in   1        module has work in flight
//  req_vld         in   NUM_REQ  activity requests; held high until acked
//  req_ack         out  NUM_REQ  req_vld & {NUM_REQ{clk_rdy}}, combinational
//  local_en        out  1        registered enable to gated clock cell
//  clk_rdy         out  1        registered: gated clock running and settled
//  clk_gated       out  1        registered: state==GATED
// BEHAVIOUR
//  idle = ctrl_gate_en & ~busy & ~|req_vld (sampled each rising edge).
//  Reset (sync, any state): state=RUN, idle_cnt=0, wake_cnt=0, local_en=1,
//   clk_rdy=1, clk_gated=0. Reset overrides all other inputs that cycle.
//  States:
//   RUN: local_en=1, clk_rdy=1. idle -> COUNT with idle_cnt=1.
//   COUNT: local_en=1, clk_rdy=1.
//    ~idle -> RUN with idle_cnt=0.
//    idle & idle_cnt==IDLE_THRESH-1 -> GATED.
//    Otherwise idle_cnt++.
//    IDLE_THRESH==1: RUN goes directly to GATED on first idle.
//   GATED: local_en=0, clk_rdy=0, clk_gated=1.
//    busy | |req_vld | ~ctrl_gate_en -> WAKE, wake_cnt=WAKE_DLY-1.
//   WAKE: local_en=1, clk_rdy=0.
//    wake_cnt==0 -> RUN (clk_rdy=1 next edge); else wake_cnt--.
//    Inputs ignored in WAKE; no re-gating until RUN reached.
//  Latency:
//   Idle from edge k..k+IDLE_THRESH-1 -> local_en low after edge k+IDLE_THRESH-1.
//   Wake seen at edge w -> local_en high after w; clk_rdy high after w+WAKE_DLY.
//  All outputs are registered state decodes except req_ack; no glitches on local_en.
//  Boundary rules:
//   Activity on the same edge the count would hit threshold -> RUN, no gating.
//   ctrl_gate_en falling in COUNT -> RUN with idle_cnt=0.
//   ctrl_gate_en falling in GATED -> WAKE (normal wake path).
//   Request arriving in GATED/WAKE: req_ack stays 0 until clk_rdy=1; requester holds.
//   idle_cnt never wraps: leaves COUNT at threshold.
//  No clk_rdy=1 cycle ever coincides with local_en=0.
// TESTING
//  1 Reset, then idle 8 edges -> local_en falls after 8th edge, clk_gated=1, clk_rdy=0.
//  2 Idle 7 edges, req_vld[2]=1 on 8th -> stays RUN, local_en=1, req_ack[2]=1 same cycle.
//  3 GATED, req_vld=4'b0001 -> local_en=1 next edge, clk_rdy=1 two edges later,
//    req_ack[0]=0 until then.
//  4 GATED, ctrl_gate_en 1->0 -> WAKE, then RUN; held low 20 cycles -> never re-gates.
//  5 cpurst=1 mid-WAKE and mid-COUNT -> next edge local_en=1, clk_rdy=1, state RUN.
//  6 Sweep IDLE_THRESH=1 and WAKE_DLY=1 -> gating after 1 idle edge, clk_rdy 1 edge after wake.

Source files
------------

// File: rtl/gated_clk_en_ctrl_if.sv
// ---------------------------------------------------------------------------
// gated_clk_en_ctrl_if
//   Activity/handshake bundle between a clock-gated module and the
//   enable controller that watches it.
//   busy     : module has work in flight
//   req_vld  : activity request lines, held high by the requester until acked
//   req_ack  : acknowledge, only asserted while the gated clock is settled
// Modports
//   master : the activity source (drives busy/req_vld, sees req_ack)
//   slave  : the enable controller
// ---------------------------------------------------------------------------
interface gated_clk_en_ctrl_if #(
  parameter int NUM_REQ = 4
);
  logic               busy;
  logic [NUM_REQ-1:0] req_vld;
  logic [NUM_REQ-1:0] req_ack;

  modport master (output busy, output req_vld, input  req_ack);
  modport slave  (input  busy, input  req_vld, output req_ack);
endinterface

// File: rtl/gated_clk_en_ctrl.sv
// ---------------------------------------------------------------------------
// gated_clk_en_ctrl
//   Idle-detect enable controller for one gated clock cell. Runs on the
//   free-running clock, drops local_en after IDLE_THRESH consecutive idle
//   cycles, and on new activity re-enables the clock while holding
//   requesters off for WAKE_DLY cycles before acknowledging.
// Ports
//   forever_cpuclk : free-running clock, never gated
//   cpurst         : synchronous reset, active-high
//   ctrl_gate_en   : 1 = gating allowed, 0 = clock forced on
//   act_if         : busy / req_vld in, req_ack out (slave modport)
//   local_en       : registered enable to the gated clock cell
//   clk_rdy        : registered, gated clock running and settled
//   clk_gated      : registered, controller is in the gated state
// ---------------------------------------------------------------------------
module gated_clk_en_ctrl #(
  parameter int NUM_REQ     = 4,
  parameter int IDLE_THRESH = 8,
  parameter int WAKE_DLY    = 2,
  parameter int CNT_W       = 4
) (
  input  logic                forever_cpuclk,
  input  logic                cpurst,
  input  logic                ctrl_gate_en,
  gated_clk_en_ctrl_if.slave  act_if,
  output logic                local_en,
  output logic                clk_rdy,
  output logic                clk_gated
);

  localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(IDLE_THRESH - 1);
  localparam logic [CNT_W-1:0] WAKE_INIT = CNT_W'(WAKE_DLY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_COUNT = 2'd1,
    ST_GATED = 2'd2,
    ST_WAKE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0]  wake_cnt_q, wake_cnt_d;
  logic              local_en_q, local_en_d;
  logic              clk_rdy_q, clk_rdy_d;
  logic              clk_gated_q, clk_gated_d;
  logic              idle;

  assign idle = ctrl_gate_en & ~act_if.busy & ~(|act_if.req_vld);

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;

    unique case (state_q)
      ST_RUN: begin
        if (idle) begin
          if (THRESH_M1 == '0) begin
            // A threshold of one gates on the very first idle edge.
            state_d    = ST_GATED;
            idle_cnt_d = '0;
          end else begin
            state_d    = ST_COUNT;
            idle_cnt_d = CNT_ONE;
          end
        end
      end
      ST_COUNT: begin
        if (!idle) begin
          // Activity on the threshold edge still wins: no gating.
          state_d    = ST_RUN;
          idle_cnt_d = '0;
        end else if (idle_cnt_q == THRESH_M1) begin
          // Leave COUNT at threshold so the counter can never wrap.
          state_d    = ST_GATED;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + CNT_ONE;
        end
      end
      ST_GATED: begin
        // ~idle covers busy, any request and ctrl_gate_en dropping.
        if (!idle) begin
          state_d    = ST_WAKE;
          wake_cnt_d = WAKE_INIT;
        end
      end
      ST_WAKE: begin
        // Inputs are ignored until the clock has settled and RUN is reached.
        if (wake_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          wake_cnt_d = wake_cnt_q - CNT_ONE;
        end
      end
      default: state_d = ST_RUN;
    endcase

    // Outputs are decoded from the next state and registered, so local_en
    // comes straight from a flop and cannot glitch.
    local_en_d  = (state_d != ST_GATED);
    clk_rdy_d   = (state_d == ST_RUN) || (state_d == ST_COUNT);
    clk_gated_d = (state_d == ST_GATED);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q     <= ST_RUN;
      idle_cnt_q  <= '0;
      wake_cnt_q  <= '0;
      local_en_q  <= 1'b1;
      clk_rdy_q   <= 1'b1;
      clk_gated_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      wake_cnt_q  <= wake_cnt_d;
      local_en_q  <= local_en_d;
      clk_rdy_q   <= clk_rdy_d;
      clk_gated_q <= clk_gated_d;
    end
  end

  assign local_en       = local_en_q;
  assign clk_rdy        = clk_rdy_q;
  assign clk_gated      = clk_gated_q;
  assign act_if.req_ack = act_if.req_vld & {NUM_REQ{clk_rdy_q}};

endmodule
